// File: rtl/config_reg_pkg.sv
// rtl/config_reg_pkg.sv - shared FSM type, default depth and byte-enable mask helper for config_reg_bank
package config_reg_pkg;

    localparam int DEFAULT_DEPTH = 24;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_RESP = 1'b1
    } state_t;

    function automatic logic [7:0] byte_mask(input logic be);
        return {8{be}};
    endfunction

endpackage

// File: rtl/config_reg_bank_ch.sv
// rtl/config_reg_bank_ch.sv - one register channel: storage, byte-enable write merge, read mux
// Optional CONFIG_REG_SHADOW_EN: writes land in shadow storage, i_commit copies it to the exported copy.
module config_reg_bank_ch
    import config_reg_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DEPTH      = DEFAULT_DEPTH,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_wr,
    input  logic [ADDR_WIDTH-1:0]       i_addr,
    input  logic [DATA_WIDTH-1:0]       i_wr_data,
    input  logic [DATA_WIDTH/8-1:0]     i_wr_be,
`ifdef CONFIG_REG_SHADOW_EN
    input  logic                        i_commit,
`endif
    output logic [DATA_WIDTH-1:0]       o_rd_data,
    output logic [DEPTH*DATA_WIDTH-1:0] o_cfg
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] r_store    [DEPTH];
    logic [DATA_WIDTH-1:0] w_store_nxt[DEPTH];

    for (genvar b = 0; b < NB; b++) begin : g_mask
        assign w_mask[b*8 +: 8] = byte_mask(i_wr_be[b]);
    end

    // The merged next value also feeds the commit path, so a write coinciding with commit is committed.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_store_nxt[i] = r_store[i];
            if (i_wr && (i_addr == ADDR_WIDTH'(i))) begin
                w_store_nxt[i] = (r_store[i] & ~w_mask) | (i_wr_data & w_mask);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_store[i] <= RST_VAL;
        end else begin
            for (int i = 0; i < DEPTH; i++) r_store[i] <= w_store_nxt[i];
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_addr == ADDR_WIDTH'(i)) o_rd_data = r_store[i];
        end
    end

`ifdef CONFIG_REG_SHADOW_EN
    logic [DATA_WIDTH-1:0] r_active[DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_active[i] <= RST_VAL;
        end else if (i_commit) begin
            for (int i = 0; i < DEPTH; i++) r_active[i] <= w_store_nxt[i];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cfg_active
        assign o_cfg[i*DATA_WIDTH +: DATA_WIDTH] = r_active[i];
    end
`else
    for (genvar i = 0; i < DEPTH; i++) begin : g_cfg_direct
        assign o_cfg[i*DATA_WIDTH +: DATA_WIDTH] = r_store[i];
    end
`endif

endmodule

// File: rtl/config_reg_bank.sv
// rtl/config_reg_bank.sv - multi-channel host config register file with chip-select bus and held read response
// Optional CONFIG_REG_SHADOW_EN adds the commit input and shadow/active register copies.
module config_reg_bank
    import config_reg_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DEPTH      = DEFAULT_DEPTH,
    parameter int                    NUM_CH     = 2,
    parameter int                    CH_WIDTH   = 1,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cs_n,
    input  logic                               wr_en,
    input  logic [CH_WIDTH-1:0]                ch_sel,
    input  logic [ADDR_WIDTH-1:0]              addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic [DATA_WIDTH/8-1:0]            wr_be,
`ifdef CONFIG_REG_SHADOW_EN
    input  logic                               commit,
`endif
    output logic [DATA_WIDTH-1:0]              rd_data,
    output logic                               resp,
    output logic                               err,
    output logic                               busy,
    output logic [NUM_CH*DEPTH*DATA_WIDTH-1:0] cfg_out
);

    localparam logic [ADDR_WIDTH:0] LP_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [CH_WIDTH:0]   LP_NUM_CH = (CH_WIDTH+1)'(NUM_CH);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_err;
    logic                  w_legal;
    logic                  w_accept;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_ch_rd[NUM_CH];

    assign w_legal     = ({1'b0, addr} < LP_DEPTH) && ({1'b0, ch_sel} < LP_NUM_CH);
    assign w_accept    = !cs_n && (r_state == IDLE);
    assign w_wr_accept = w_accept && wr_en && w_legal;
    assign w_rd_accept = w_accept && !wr_en;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [CH_WIDTH-1:0] LP_CH = CH_WIDTH'(c);
        config_reg_bank_ch #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (DEPTH),
            .RST_VAL    (RST_VAL)
        ) u_ch (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_wr       (w_wr_accept && (ch_sel == LP_CH)),
            .i_addr     (addr),
            .i_wr_data  (wr_data),
            .i_wr_be    (wr_be),
`ifdef CONFIG_REG_SHADOW_EN
            .i_commit   (commit),
`endif
            .o_rd_data  (w_ch_rd[c]),
            .o_cfg      (cfg_out[c*DEPTH*DATA_WIDTH +: DEPTH*DATA_WIDTH])
        );
    end

    always_comb begin
        w_rd_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == CH_WIDTH'(c)) w_rd_word = w_ch_rd[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Write responses are combinational in IDLE; read responses come from RD_RESP and hold until cs_n rises.
    always_comb begin
        w_state_nxt = r_state;
        resp        = 1'b0;
        err         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rd_accept) w_state_nxt = RD_RESP;
                if (w_accept && wr_en) begin
                    resp = 1'b1;
                    err  = !w_legal;
                end
            end
            RD_RESP: begin
                resp = 1'b1;
                err  = r_err;
                if (cs_n) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
            r_err     <= 1'b0;
        end else if (w_rd_accept) begin
            r_rd_data <= w_legal ? w_rd_word : '0;
            r_err     <= !w_legal;
        end
    end

    assign rd_data = r_rd_data;
    assign busy    = (r_state == RD_RESP);

endmodule

// File: tb/tb_config_reg_bank.sv
// tb/tb_config_reg_bank.sv - directed self-checking bench for config_reg_bank (CONFIG_REG_SHADOW_EN aware)
module tb_config_reg_bank;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 24;
    localparam int NCH   = 2;
    localparam int CW    = 1;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              cs_n    = 1'b1;
    logic              wr_en   = 1'b0;
    logic [CW-1:0]     ch_sel  = '0;
    logic [AW-1:0]     addr    = '0;
    logic [DW-1:0]     wr_data = '0;
    logic [3:0]        wr_be   = '0;
`ifdef CONFIG_REG_SHADOW_EN
    logic              commit  = 1'b0;
`endif
    logic [DW-1:0]           rd_data, rd_data1;
    logic                    resp, err, busy, resp1, err1, busy1;
    logic [NCH*DEPTH*DW-1:0] cfg_out;
    logic [DEPTH*DW-1:0]     cfg_out1;
    logic [NCH*DEPTH*DW-1:0] exp_cfg = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    config_reg_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_CH(NCH), .CH_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_en(wr_en), .ch_sel(ch_sel), .addr(addr),
        .wr_data(wr_data), .wr_be(wr_be),
`ifdef CONFIG_REG_SHADOW_EN
        .commit(commit),
`endif
        .rd_data(rd_data), .resp(resp), .err(err), .busy(busy), .cfg_out(cfg_out)
    );

    config_reg_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_CH(1), .CH_WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_en(wr_en), .ch_sel(ch_sel), .addr(addr),
        .wr_data(wr_data), .wr_be(wr_be),
`ifdef CONFIG_REG_SHADOW_EN
        .commit(commit),
`endif
        .rd_data(rd_data1), .resp(resp1), .err(err1), .busy(busy1), .cfg_out(cfg_out1)
    );

    task automatic drive(input logic c, input logic w, input logic [CW-1:0] ch, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] be);
        @(negedge clk);
        cs_n = c; wr_en = w; ch_sel = ch; addr = a; wr_data = d; wr_be = be;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    endtask

    task automatic sync_active();
`ifdef CONFIG_REG_SHADOW_EN
        @(negedge clk); commit = 1'b1;
        @(negedge clk); commit = 1'b0;
`else
        @(negedge clk);
`endif
    endtask

    task automatic test_reset();
        #12;
        checks++; if (resp !== 1'b0) begin errors++; $display("FAIL reset_resp actual=%0b required=0", resp); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err actual=%0b required=0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%0b required=0", busy); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data actual=%0h required=0", rd_data); end
        checks++; if (cfg_out !== exp_cfg) begin errors++; $display("FAIL reset_cfg_out not all zero"); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_read_after_reset();
        drive(1'b0, 1'b0, 1'b0, 5'd3, 32'h0, 4'h0);
        #1;
        checks++; if (resp !== 1'b0) begin errors++; $display("FAIL rd_resp_early actual=%0b required=0", resp); end
        @(posedge clk); #1;
        checks++; if (resp !== 1'b1 || err !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL rd_rsp_flags actual=%0b%0b%0b required=101", resp, err, busy); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL rd_reset_val actual=%0h required=0", rd_data); end
        @(posedge clk); #1;
        checks++; if (resp !== 1'b1 || busy !== 1'b1) begin errors++;
            $display("FAIL rd_hold actual=%0b%0b required=11", resp, busy); end
        idle();
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0 || resp !== 1'b0) begin errors++;
            $display("FAIL rd_release actual=%0b%0b required=00", busy, resp); end
    endtask

    task automatic test_write_be();
        drive(1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 4'b0101);
        #1;
        checks++; if (resp !== 1'b1 || err !== 1'b0) begin errors++;
            $display("FAIL wr_resp actual=%0b%0b required=10", resp, err); end
        idle(); sync_active();
        exp_cfg[(1*DEPTH+5)*DW +: DW] = 32'h00AD00EF;
        checks++; if (cfg_out[(1*DEPTH+5)*DW +: DW] !== 32'h00AD00EF) begin errors++;
            $display("FAIL wr_be_cfg actual=%0h required=00ad00ef", cfg_out[(1*DEPTH+5)*DW +: DW]); end
        drive(1'b0, 1'b0, 1'b1, 5'd5, 32'h0, 4'h0);
        @(posedge clk); #1;
        checks++; if (rd_data !== 32'h00AD00EF || resp !== 1'b1) begin errors++;
            $display("FAIL wr_be_readback actual=%0h required=00ad00ef", rd_data); end
        idle();
        drive(1'b0, 1'b1, 1'b1, 5'd5, 32'h11223344, 4'b1010);
        idle(); sync_active();
        exp_cfg[(1*DEPTH+5)*DW +: DW] = 32'h11AD33EF;
        checks++; if (cfg_out[(1*DEPTH+5)*DW +: DW] !== 32'h11AD33EF) begin errors++;
            $display("FAIL wr_be_merge actual=%0h required=11ad33ef", cfg_out[(1*DEPTH+5)*DW +: DW]); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 5'(10 + i), 32'(256 + i), 4'hF);
            #1;
            checks++; if (resp !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin errors++;
                $display("FAIL b2b_resp idx=%0d actual=%0b%0b%0b required=100", i, resp, err, busy); end
            exp_cfg[(10+i)*DW +: DW] = 32'(256 + i);
        end
        idle(); sync_active();
        checks++; if (cfg_out !== exp_cfg) begin errors++; $display("FAIL b2b_cfg actual=%0h required=%0h",
            cfg_out[10*DW +: 4*DW], exp_cfg[10*DW +: 4*DW]); end
    endtask

    task automatic test_illegal_write();
        drive(1'b0, 1'b1, 1'b0, 5'd24, 32'h12345678, 4'hF);
        #1;
        checks++; if (resp !== 1'b1 || err !== 1'b1) begin errors++;
            $display("FAIL illwr_resp actual=%0b%0b required=11", resp, err); end
        drive(1'b0, 1'b1, 1'b1, 5'd31, 32'h9ABCDEF0, 4'hF);
        #1;
        checks++; if (resp !== 1'b1 || err !== 1'b1) begin errors++;
            $display("FAIL illwr31_resp actual=%0b%0b required=11", resp, err); end
        idle(); sync_active();
        checks++; if (cfg_out !== exp_cfg) begin errors++; $display("FAIL illwr_cfg actual=%0h required=%0h",
            cfg_out[DEPTH*DW +: DW], exp_cfg[DEPTH*DW +: DW]); end
    endtask

    task automatic test_illegal_channel();
        drive(1'b0, 1'b1, 1'b0, 5'd2, 32'hCAFEF00D, 4'hF);
        idle(); sync_active();
        exp_cfg[2*DW +: DW] = 32'hCAFEF00D;
        checks++; if (cfg_out1 !== exp_cfg[0 +: DEPTH*DW]) begin errors++;
            $display("FAIL ch1dut_cfg actual=%0h required=cafef00d", cfg_out1[2*DW +: DW]); end
        drive(1'b0, 1'b0, 1'b1, 5'd2, 32'h0, 4'h0);
        @(posedge clk); #1;
        checks++; if (resp1 !== 1'b1 || err1 !== 1'b1 || busy1 !== 1'b1) begin errors++;
            $display("FAIL illch_flags actual=%0b%0b%0b required=111", resp1, err1, busy1); end
        checks++; if (rd_data1 !== 32'h0) begin errors++; $display("FAIL illch_rd actual=%0h required=0", rd_data1); end
        checks++; if (err !== 1'b0 || rd_data !== 32'h0) begin errors++;
            $display("FAIL legal_ch1_rd actual=%0b/%0h required=0/0", err, rd_data); end
        idle();
        drive(1'b0, 1'b0, 1'b0, 5'd30, 32'h0, 4'h0);
        @(posedge clk); #1;
        checks++; if (resp !== 1'b1 || err !== 1'b1 || rd_data !== 32'h0) begin errors++;
            $display("FAIL illaddr_rd actual=%0b%0b/%0h required=11/0", resp, err, rd_data); end
        idle();
    endtask

    task automatic test_busy_ignore();
        drive(1'b0, 1'b1, 1'b0, 5'd7, 32'h55, 4'hF);
        idle(); sync_active();
        exp_cfg[7*DW +: DW] = 32'h55;
        drive(1'b0, 1'b0, 1'b0, 5'd7, 32'h0, 4'h0);
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1 || rd_data !== 32'h55) begin errors++;
            $display("FAIL busy_rd actual=%0b/%0h required=1/55", busy, rd_data); end
        drive(1'b0, 1'b1, 1'b0, 5'd7, 32'hFFFFFFFF, 4'hF);
        #1;
        checks++; if (resp !== 1'b1 || err !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL busy_wr_resp actual=%0b%0b%0b required=101", resp, err, busy); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1 || rd_data !== 32'h55) begin errors++;
            $display("FAIL busy_hold actual=%0b/%0h required=1/55", busy, rd_data); end
        idle(); sync_active();
        checks++; if (cfg_out !== exp_cfg) begin errors++; $display("FAIL busy_cfg actual=%0h required=55",
            cfg_out[7*DW +: DW]); end
        drive(1'b0, 1'b0, 1'b0, 5'd7, 32'h0, 4'h0);
        @(posedge clk); #1;
        checks++; if (rd_data !== 32'h55) begin errors++; $display("FAIL busy_readback actual=%0h required=55", rd_data); end
        idle();
    endtask

    task automatic test_reset_mid_read();
        drive(1'b0, 1'b0, 1'b1, 5'd5, 32'h0, 4'h0);
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1 || rd_data !== 32'h11AD33EF) begin errors++;
            $display("FAIL midrst_pre actual=%0b/%0h required=1/11ad33ef", busy, rd_data); end
        #2; rst_n = 1'b0; cs_n = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || resp !== 1'b0 || err !== 1'b0 || rd_data !== 32'h0) begin errors++;
            $display("FAIL midrst_clear actual=%0b%0b%0b/%0h required=000/0", busy, resp, err, rd_data); end
        exp_cfg = '0;
        checks++; if (cfg_out !== exp_cfg) begin errors++; $display("FAIL midrst_cfg not all zero"); end
        @(negedge clk); rst_n = 1'b1;
    endtask

`ifdef CONFIG_REG_SHADOW_EN
    task automatic test_shadow();
        drive(1'b0, 1'b1, 1'b0, 5'd0, 32'hA5, 4'hF);
        idle(); #1;
        checks++; if (cfg_out[0 +: DW] !== 32'h0) begin errors++;
            $display("FAIL shadow_precommit actual=%0h required=0", cfg_out[0 +: DW]); end
        @(negedge clk); commit = 1'b1;
        @(negedge clk); commit = 1'b0;
        checks++; if (cfg_out[0 +: DW] !== 32'hA5) begin errors++;
            $display("FAIL shadow_commit actual=%0h required=a5", cfg_out[0 +: DW]); end
        @(negedge clk); cs_n = 1'b0; wr_en = 1'b1; addr = 5'd1; wr_data = 32'h77; wr_be = 4'hF; commit = 1'b1;
        @(negedge clk); cs_n = 1'b1; wr_en = 1'b0; commit = 1'b0;
        checks++; if (cfg_out[DW +: DW] !== 32'h77) begin errors++;
            $display("FAIL shadow_coincident actual=%0h required=77", cfg_out[DW +: DW]); end
    endtask
`endif

    initial begin
        test_reset();
        test_read_after_reset();
        test_write_be();
        test_back_to_back();
        test_illegal_write();
        test_illegal_channel();
        test_busy_ignore();
        test_reset_mid_read();
`ifdef CONFIG_REG_SHADOW_EN
        test_shadow();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
